// File: rtl/display_pkg.sv
// Shared segment indices and segment-to-duty-group mapping for the PWM scan display driver.
package display_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic [1:0] {GRP_L, GRP_M, GRP_R} grp_e;

  localparam grp_e GRP_OF_A = GRP_M;
  localparam grp_e GRP_OF_B = GRP_R;
  localparam grp_e GRP_OF_C = GRP_R;
  localparam grp_e GRP_OF_D = GRP_M;
  localparam grp_e GRP_OF_E = GRP_L;
  localparam grp_e GRP_OF_F = GRP_L;
  localparam grp_e GRP_OF_G = GRP_M;

  // lit holds the per-group compare result: bit0 left, bit1 middle, bit2 right.
  function automatic logic grp_lit(input grp_e g, input logic [2:0] lit);
    case (g)
      GRP_L:   return lit[0];
      GRP_M:   return lit[1];
      GRP_R:   return lit[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pwm_scan_timer.sv
// Slot / digit / PWM-frame counters for the scan driver; flags blank phase and frame edges.
module pwm_scan_timer
  import display_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int PWM_W  = 8,
  parameter int DWELL  = 128,
  parameter int BLANK  = 2,
  localparam int DIG_W  = $clog2(DIGITS),
  localparam int SLOT_W = $clog2(DWELL) + 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [DIG_W-1:0] dig_idx,
  output logic [PWM_W-1:0] pwm_cnt,
  output logic             blank,
  output logic             frame_end,
  output logic             frame_start_pre
);

  logic [SLOT_W-1:0] slot_cnt;
  logic              slot_end;
  logic              dig_end;

  assign slot_end        = (slot_cnt == SLOT_W'(DWELL - 1));
  assign dig_end         = (dig_idx == DIG_W'(DIGITS - 1));
  assign frame_end       = slot_end && dig_end;
  assign frame_start_pre = (slot_cnt == '0) && (dig_idx == '0);

  generate
    if (BLANK == 0) begin : g_no_blank
      assign blank = 1'b0;
    end else begin : g_blank
      assign blank = (slot_cnt < SLOT_W'(BLANK));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
      pwm_cnt  <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      if (dig_end) begin
        dig_idx <= '0;
        pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
        dig_idx <= dig_idx + 1'b1;
      end
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_scan_display_driver.sv
// Time-multiplexed 7-segment PWM driver with blanking and tear-free double-buffered duties.
// Optional DISPLAY_GAMMA_EN squares each duty ((d*d) >> PWM_W) before comparison.
module pwm_scan_display_driver
  import display_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int PWM_W  = 8,
  parameter int DWELL  = 128,
  parameter int BLANK  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIGITS*3*PWM_W-1:0] duty_in,
  input  logic [DIGITS-1:0]         dp_in,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  output logic [7:0]                sseg,
  output logic [DIGITS-1:0]         digit,
  output logic                      frame_start
);

  localparam int DW    = 3 * PWM_W;
  localparam int DIG_W = $clog2(DIGITS);

  logic [DIG_W-1:0]         dig_idx;
  logic [PWM_W-1:0]         pwm_cnt;
  logic                     blank;
  logic                     frame_end;
  logic                     frame_start_pre;

  logic [DIGITS*DW-1:0]     active;
  logic [DIGITS*DW-1:0]     pending;
  logic [DW-1:0]            cur;
  logic [2:0]               lit;
  logic [7:0]               sseg_d;
  logic [DIGITS-1:0]        digit_d;

  pwm_scan_timer #(
    .DIGITS (DIGITS),
    .PWM_W  (PWM_W),
    .DWELL  (DWELL),
    .BLANK  (BLANK)
  ) u_timer (
    .clk             (clk),
    .reset           (reset),
    .dig_idx         (dig_idx),
    .pwm_cnt         (pwm_cnt),
    .blank           (blank),
    .frame_end       (frame_end),
    .frame_start_pre (frame_start_pre)
  );

  function automatic logic [PWM_W-1:0] shape(input logic [PWM_W-1:0] d);
`ifdef DISPLAY_GAMMA_EN
    logic [2*PWM_W-1:0] p;
    p = {{PWM_W{1'b0}}, d} * {{PWM_W{1'b0}}, d};
    return p[2*PWM_W-1:PWM_W];
`else
    return d;
`endif
  endfunction

  // upd_ready low means pending holds data awaiting the next frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      active    <= '0;
      pending   <= '0;
      upd_ready <= 1'b1;
    end else if (upd_valid && upd_ready) begin
      pending   <= duty_in;
      upd_ready <= 1'b0;
    end else if (frame_end && !upd_ready) begin
      active    <= pending;
      upd_ready <= 1'b1;
    end
  end

  assign cur = active[int'(dig_idx)*DW +: DW];

  always_comb begin
    lit[0] = (pwm_cnt < shape(cur[0       +: PWM_W]));
    lit[1] = (pwm_cnt < shape(cur[PWM_W   +: PWM_W]));
    lit[2] = (pwm_cnt < shape(cur[2*PWM_W +: PWM_W]));
  end

  always_comb begin
    sseg_d         = '0;
    digit_d        = '1;
    if (!blank) begin
      sseg_d[SEG_A]  = grp_lit(GRP_OF_A, lit);
      sseg_d[SEG_B]  = grp_lit(GRP_OF_B, lit);
      sseg_d[SEG_C]  = grp_lit(GRP_OF_C, lit);
      sseg_d[SEG_D]  = grp_lit(GRP_OF_D, lit);
      sseg_d[SEG_E]  = grp_lit(GRP_OF_E, lit);
      sseg_d[SEG_F]  = grp_lit(GRP_OF_F, lit);
      sseg_d[SEG_G]  = grp_lit(GRP_OF_G, lit);
      sseg_d[SEG_DP] = dp_in[dig_idx];
      digit_d        = ~(DIGITS'(1) << dig_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sseg        <= '0;
      digit       <= '1;
      frame_start <= 1'b0;
    end else begin
      sseg        <= sseg_d;
      digit       <= digit_d;
      frame_start <= frame_start_pre;
    end
  end

endmodule
